tvip_apb_sram_slave: RTL and testbench

// Synthesizable APB completer: a word-addressed SRAM behind an APB3/APB4 slave port.

---
 rtl/tvip_apb_sram_slave.sv | 186 ++++++++++++++++++
 tb/tb_tvip_apb_sram_slave.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tvip_apb_sram_slave.sv
// tvip_apb_sram_slave
//
// APB3/APB4 completer that fronts a word-addressed SRAM. It acts as a loopback
// target for the APB master agent in VIP self-tests. Every transfer goes
// IDLE -> ACCESS -> IDLE. The number of wait states is taken from wait_cycles
// when the setup phase is seen. The error decision (unaligned, out of range, or
// unprivileged when PRIV_ONLY is set) is made once, at setup. An error write
// never touches the array, and an error read returns zero. When the master
// breaks the setup/access handshake, protocol_error pulses for one cycle.
//
// Ports
//   pclk            clock; all state changes on the rising edge
//   preset_n        asynchronous active-low reset (the SRAM contents are kept)
//   psel, penable   APB select and access-phase enable
//   paddr           byte address
//   pprot           protection attributes; bit 0 = privileged
//   pwrite          1 = write, 0 = read
//   pwdata, pstrb   write data and byte strobes, taken at the completion edge
//   pready          registered transfer-complete flag
//   prdata          registered read data
//   pslverr         registered error response, valid with pready
//   wait_cycles     wait states to insert, sampled at setup only
//   protocol_error  one-cycle pulse when the master violates the handshake

module tvip_apb_sram_slave #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 256,
    parameter bit PRIV_ONLY     = 1'b0
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic [ADDRESS_WIDTH-1:0] paddr,
    input  logic [2:0]              pprot,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr,
    input  logic [3:0]              wait_cycles,
    output logic                    protocol_error
);

    localparam int STRB_WIDTH   = DATA_WIDTH / 8;
    localparam int OFFSET_WIDTH = $clog2(STRB_WIDTH);
    localparam int INDEX_WIDTH  = $clog2(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK = ADDRESS_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    write_q, write_d;
    logic [INDEX_WIDTH-1:0]  idx_q, idx_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    protocol_error_q, protocol_error_d;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDRESS_WIDTH-1:0] word_addr;
    logic [INDEX_WIDTH-1:0]   setup_idx;
    logic                     setup_err;
    logic                     unused_prot;

    // pprot[2:1] (secure / instruction) carry no meaning for this target.
    assign unused_prot = ^pprot[2:1];

    // Decode the setup-phase address. Out-of-range addresses are flagged, not
    // wrapped. This matters because the truncated index would otherwise alias
    // onto a real word.
    always_comb begin
        word_addr = paddr >> OFFSET_WIDTH;
        setup_idx = word_addr[INDEX_WIDTH-1:0];
        setup_err = ((paddr & OFFSET_MASK) != '0)
                 || ((word_addr >> INDEX_WIDTH) != '0)
                 || (PRIV_ONLY && !pprot[0]);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            err_q            <= 1'b0;
            write_q          <= 1'b0;
            idx_q            <= '0;
            pready_q         <= 1'b0;
            pslverr_q        <= 1'b0;
            prdata_q         <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            err_q            <= err_d;
            write_q          <= write_d;
            idx_q            <= idx_d;
            pready_q         <= pready_d;
            pslverr_q        <= pslverr_d;
            prdata_q         <= prdata_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    // Next-state logic. Read data is fetched at setup and then held through the
    // wait states. The array is written only on the completion edge, so an
    // abort or a reset in the middle of a transfer never commits a write.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        err_d            = err_q;
        write_d          = write_q;
        idx_d            = idx_q;
        pready_d         = pready_q;
        pslverr_d        = pslverr_q;
        prdata_d         = prdata_q;
        protocol_error_d = 1'b0;
        mem_we           = 1'b0;

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d   = ACCESS;
                    cnt_d     = wait_cycles;
                    err_d     = setup_err;
                    write_d   = pwrite;
                    idx_d     = setup_idx;
                    pready_d  = (wait_cycles == 4'd0);
                    pslverr_d = setup_err && (wait_cycles == 4'd0);
                    prdata_d  = (!pwrite && !setup_err) ? mem[setup_idx] : '0;
                end else if (psel && penable) begin
                    protocol_error_d = 1'b1;
                end
            end
            ACCESS: begin
                if (psel && penable) begin
                    if (pready_q) begin
                        mem_we    = write_q && !err_q;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            pready_d  = 1'b1;
                            pslverr_d = err_q;
                        end
                    end
                end else begin
                    protocol_error_d = 1'b1;
                    pready_d         = 1'b0;
                    pslverr_d        = 1'b0;
                    prdata_d         = '0;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The SRAM array has no reset, so its contents survive preset_n.
    always_ff @(posedge pclk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (pstrb[i]) begin
                    mem[idx_q][8*i +: 8] <= pwdata[8*i +: 8];
                end
            end
        end
    end

    assign pready         = pready_q;
    assign pslverr        = pslverr_q;
    assign prdata         = prdata_q;
    assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_tvip_apb_sram_slave.sv
// tb_tvip_apb_sram_slave
//
// Self-checking bench for tvip_apb_sram_slave. Two instances share every input:
// u_dut (PRIV_ONLY=0) and u_priv (PRIV_ONLY=1). The stimulus tasks work out
// each transfer's expected response from a word-array model of the SRAM and
// queue it. A monitor on the falling edge pops the queue and compares whenever
// a transfer completes (psel & penable & pready).

module tb_tvip_apb_sram_slave;

    logic        pclk;
    logic        preset_n;
    logic        psel;
    logic        penable;
    logic [15:0] paddr;
    logic [2:0]  pprot;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [3:0]  wait_cycles;

    logic        pready,   pready_p;
    logic [31:0] prdata,   prdata_p;
    logic        pslverr,  pslverr_p;
    logic        protocol_error, protocol_error_p;

    typedef struct {
        logic [31:0] rd0;
        logic        err0;
        logic [31:0] rd1;
        logic        err1;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model0 [256];
    logic [31:0] model1 [256];
    int          checks;
    int          errors;

    tvip_apb_sram_slave #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256), .PRIV_ONLY(1'b0)
    ) u_dut (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .paddr(paddr), .pprot(pprot), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .wait_cycles(wait_cycles), .protocol_error(protocol_error)
    );

    tvip_apb_sram_slave #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(32), .DEPTH(256), .PRIV_ONLY(1'b1)
    ) u_priv (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .paddr(paddr), .pprot(pprot), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pready(pready_p), .prdata(prdata_p), .pslverr(pslverr_p),
        .wait_cycles(wait_cycles), .protocol_error(protocol_error_p)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // An access is in error when it is unaligned, lies past the last word, or is
    // unprivileged on the PRIV_ONLY instance.
    function automatic bit addrErr(input logic [15:0] a, input logic [2:0] prot, input bit priv);
        return ((a % 16'd4) != 16'd0) || ((a / 16'd4) >= 16'd256) || (priv && (prot[0] == 1'b0));
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    // One complete APB transfer. The expected response is queued before the
    // setup phase. Address, direction, protection and wait count are scrambled
    // during the access phase, and the DUT must ignore them there.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [2:0] prot, input logic [3:0] ws);
        exp_t e;
        int   w;
        int   waited;
        e.err0 = addrErr(addr, prot, 1'b0);
        e.err1 = addrErr(addr, prot, 1'b1);
        e.rd0  = 32'h0;
        e.rd1  = 32'h0;
        w      = int'(addr / 16'd4);
        if (!e.err0) begin
            if (wr) model0[w] = mergeBytes(model0[w], data, strb);
            else    e.rd0 = model0[w];
        end
        if (!e.err1) begin
            if (wr) model1[w] = mergeBytes(model1[w], data, strb);
            else    e.rd1 = model1[w];
        end
        exp_q.push_back(e);

        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = data; pstrb = strb; pprot = prot; wait_cycles = ws;
        @(posedge pclk); #1;
        penable     = 1'b1;
        paddr       = 16'($urandom);
        pwrite      = ~wr;
        pprot       = 3'($urandom);
        wait_cycles = 4'($urandom);
        waited      = 0;
        while (!pready && waited < 40) begin
            @(posedge pclk); #1;
            waited++;
        end
        if (!pready) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: pready still 0 after %0d cycles, expected %0d", waited, ws);
            void'(exp_q.pop_back());
        end else begin
            checkOutput("latency", 64'(waited), 64'(ws));
            @(posedge pclk); #1;
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    // Drop psel during a wait state. The write must not be committed.
    task automatic abortTransfer(input logic [15:0] addr, input logic [31:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr;
        pwdata = data; pstrb = 4'hF; pprot = 3'b001; wait_cycles = 4'd3;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        checkOutput("abort_protocol_error", protocol_error, 1'b1);
        checkOutput("abort_protocol_error_priv", protocol_error_p, 1'b1);
        checkOutput("abort_pready", pready, 1'b0);
        @(posedge pclk); #1;
        checkOutput("abort_pulse_width", protocol_error, 1'b0);
    endtask

    // Assert reset during a transfer. The outputs must clear at once, with no
    // clock edge, and the transfer must be dropped.
    task automatic resetMidTransfer(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                                    input logic [3:0] ws, input int edges);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = data; pstrb = 4'hF; pprot = 3'b001; wait_cycles = ws;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (edges) begin
            @(posedge pclk); #1;
        end
        #1 preset_n = 1'b0;
        #1;
        checkOutput("rst_pready", pready, 1'b0);
        checkOutput("rst_prdata", prdata, 32'h0);
        checkOutput("rst_pslverr", pslverr, 1'b0);
        checkOutput("rst_protocol_error", protocol_error, 1'b0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        preset_n = 1'b1;
        @(posedge pclk); #1;
    endtask

    // Completion monitor: pops one expectation per finished transfer.
    always @(negedge pclk) begin
        if (preset_n && psel && penable && pready) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_ready", 1'b1, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("prdata", prdata, mon_e.rd0);
                checkOutput("pslverr", pslverr, mon_e.err0);
                checkOutput("pready_priv", pready_p, 1'b1);
                checkOutput("prdata_priv", prdata_p, mon_e.rd1);
                checkOutput("pslverr_priv", pslverr_p, mon_e.err1);
                checkOutput("protocol_error_quiet", protocol_error, 1'b0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] widx;
        checks = 0; errors = 0;
        preset_n = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pprot = '0;
        pwrite = 1'b0; pwdata = '0; pstrb = '0; wait_cycles = '0;
        #1;
        checkOutput("reset_pready", pready, 1'b0);
        checkOutput("reset_prdata", prdata, 32'h0);
        checkOutput("reset_pslverr", pslverr, 1'b0);
        checkOutput("reset_protocol_error", protocol_error, 1'b0);
        checkOutput("reset_pready_priv", pready_p, 1'b0);
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        preset_n = 1'b1;
        @(posedge pclk); #1;

        $display("[TB] filling memory");
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 16'(i * 4), $urandom, 4'hF, 3'b001, 4'd0);
        end

        $display("[TB] directed transfers");
        applyStimulus(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b001, 4'd0);
        applyStimulus(1'b0, 16'h0010, 32'h0, 4'h0, 3'b001, 4'd0);
        applyStimulus(1'b1, 16'h0020, 32'hFFFFFFFF, 4'hF, 3'b001, 4'd0);
        applyStimulus(1'b1, 16'h0020, 32'h11223344, 4'h5, 3'b001, 4'd0);
        applyStimulus(1'b0, 16'h0020, 32'h0, 4'h0, 3'b001, 4'd0);
        applyStimulus(1'b0, 16'h0010, 32'h0, 4'h0, 3'b001, 4'd3);
        applyStimulus(1'b1, 16'h0400, 32'h12345678, 4'hF, 3'b001, 4'd0);
        applyStimulus(1'b0, 16'h0400, 32'h0, 4'h0, 3'b001, 4'd2);
        applyStimulus(1'b1, 16'h0002, 32'h87654321, 4'hF, 3'b001, 4'd1);
        applyStimulus(1'b0, 16'h0002, 32'h0, 4'h0, 3'b001, 4'd0);
        applyStimulus(1'b0, 16'h0000, 32'h0, 4'h0, 3'b001, 4'd0);
        applyStimulus(1'b1, 16'h0040, 32'hA5A5A5A5, 4'hF, 3'b000, 4'd0);
        applyStimulus(1'b0, 16'h0040, 32'h0, 4'h0, 3'b001, 4'd0);
        applyStimulus(1'b1, 16'h0040, 32'h5A5A5A5A, 4'hF, 3'b001, 4'd1);
        applyStimulus(1'b0, 16'h0040, 32'h0, 4'h0, 3'b001, 4'd0);

        $display("[TB] protocol violations");
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 16'h0010;
        @(posedge pclk); #1;
        checkOutput("nosetup_protocol_error", protocol_error, 1'b1);
        checkOutput("nosetup_pready", pready, 1'b0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        checkOutput("nosetup_pulse_width", protocol_error, 1'b0);
        abortTransfer(16'h0010, 32'hBAD0BAD0);
        applyStimulus(1'b0, 16'h0010, 32'h0, 4'h0, 3'b001, 4'd0);

        $display("[TB] reset during transfers");
        resetMidTransfer(1'b0, 16'h0010, 32'h0, 4'd0, 0);
        resetMidTransfer(1'b1, 16'h0010, 32'h0BADF00D, 4'd4, 2);
        applyStimulus(1'b0, 16'h0010, 32'h0, 4'h0, 3'b001, 4'd0);

        $display("[TB] random transfers");
        for (int n = 0; n < 150; n++) begin
            logic [15:0] a;
            widx = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 85) a = {6'b0, widx, 2'b00};
            else                            a = 16'($urandom);
            applyStimulus(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom),
                          4'($urandom_range(0, 4)));
        end

        repeat (3) @(posedge pclk);
        #1;
        checkOutput("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
